mod_m_prog_counter: RTL and testbench
=====================================

Name: mod_m_prog_counter

Overview:
- Next-generation modulus counter: N-bit up/down counter whose modulus is set at run time.
- Adds count enable, synchronous clear, parallel load, double-buffered modulus update, and per-direction terminal ticks for cascading.
- Used as the common timebase/prescaler for baud generators, debouncers and display scanners, where the modulus is fixed at run time rather than at elaboration.

Parameters:
- N, 4, counter and modulus width in bits.
- M, 10, reset-time modulus; legal range 2..2^N-1.
- UPD_IMMEDIATE, 0, 0 = new modulus takes effect at next wrap/clear/load; 1 = takes effect on the cycle after mod_wr.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction; 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- ld  in  1  synchronous parallel load.
- ld_val  in  N  load value.
- mod_wr  in  1  modulus write strobe.
- mod_in  in  N  new modulus value.
- q  out  N  current count (registered).
- mod_q  out  N  active modulus (registered).
- max_tick  out  1  en & up & (q == mod_q-1), combinational.
- min_tick  out  1  en & ~up & (q == 0), combinational.

Behaviour:
- Reset (reset_n low, asynchronous assert, released synchronously by the clock): q=0, mod_q=M, pending modulus=M, pend_valid=0. Ticks are 0 because they depend on en.
- Effective modulus: a written mod_in of 0 or 1 is stored as 1. With modulus 1, q stays 0 and max_tick/min_tick fire on every enabled cycle in the matching direction.
- Per-cycle priority: clr > ld > en step > hold.
- clr: q<=0 next cycle.
- ld: q<=min(ld_val, mod_q-1), saturating, using the modulus that is active after this cycle's modulus update.
- Step up: if q >= mod_q-1 then q<=0 (wrap), else q<=q+1.
- Step down: if q == 0 then q<=mod_q-1 (wrap). Else if q > mod_q-1 then q<=mod_q-1. Else q<=q-1.
- Latency: q updates one cycle after the controlling input. Ticks are valid in the same cycle as the wrapping step, so a cascaded stage uses a tick as its en.
- Modulus update, UPD_IMMEDIATE=0:
  - mod_wr captures mod_in into the pending register and sets pend_valid; a later mod_wr overwrites it.
  - The pending value is copied to mod_q, and pend_valid is cleared, on any cycle that has a wrap (up or down), clr or ld.
  - The wrap/clr/ld of that cycle still uses the old mod_q to compute q. ld saturation uses the new value.
- Modulus update, UPD_IMMEDIATE=1:
  - mod_q<=mod_in on the cycle after mod_wr; pending register unused.
  - If q is then >= mod_q, the next up step wraps to 0 without asserting max_tick, and the next down step goes to mod_q-1.
- Simultaneous mod_wr and wrap (mode 0): the wrap applies the previously pending value, or none. The newly written value becomes pending.
- en low: q holds, ticks are 0, pending stays pending (clr/ld still apply it).
- All arithmetic is N-bit unsigned; mod_q-1 never underflows because mod_q >= 1.
- Reset asserted mid-operation: immediate return to reset values; the pending modulus is discarded.

Decomposition:
- Shared package holds no typedefs. It holds constants only: MOD_MIN=1, and the UPD_IMMEDIATE encodings (UPD_AT_WRAP=0, UPD_NOW=1).
- One natural sub-module: mod_shadow_reg, the pending/active modulus pair with its apply strobe, so the UART baud block can reuse it.
- The counter datapath stays in the top module.

Test Plan:
- Reset default: reset_n low then high, en=1, up=1 for 25 cycles -> q runs 0..9 twice and reaches 4; max_tick high exactly in the cycles with q=9.
- Down count: up=0 from q=0 -> q=9 next cycle, min_tick high in the q=0 cycle; q then counts 9,8,..,0.
- Shadow update (mode 0): mod_wr with mod_in=5 while q=3 -> mod_q stays 10 until q 9->0, then mod_q=5 and q cycles 0..4. Repeat with mod_in=1 -> q stays 0 and max_tick is high every enabled cycle.
- Priority and saturation: clr=1, ld=1, en=1 together -> q=0. Then ld=1, ld_val=15 with mod_q=10 -> q=9.
- Immediate mode (UPD_IMMEDIATE=1): q=8, mod_wr mod_in=4 -> mod_q=4 next cycle; next up step gives q=0 with no max_tick. Alternatively, a down step gives q=3.
- Async reset mid-run: reset_n low at q=6 between clock edges -> q=0 and mod_q=10 immediately; a pending mod_wr issued before the reset is not applied after release.

Source files
------------

// File: rtl/mod_m_prog_counter_pkg.sv
// Shared constants for the programmable modulus counter and its modulus shadow register.
package mod_m_prog_counter_pkg;
  localparam int unsigned MOD_MIN     = 32'd1;
  localparam int unsigned UPD_AT_WRAP = 32'd0;
  localparam int unsigned UPD_NOW     = 32'd1;
endpackage

// File: rtl/mod_shadow_reg.sv
// Pending/active modulus pair; the pending value moves to active on an apply strobe,
// or the written value goes straight to active when IMMEDIATE selects it.
module mod_shadow_reg
  import mod_m_prog_counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int M         = 10,
  parameter int IMMEDIATE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [N-1:0] wr_val,
  input  logic         apply,
  output logic [N-1:0] active,
  output logic [N-1:0] active_nxt
);
  localparam logic [N-1:0] M_N   = M[N-1:0];
  localparam logic [N-1:0] MIN_N = N'(MOD_MIN);

  logic [N-1:0] act_r, pend_r, eff_s;
  logic [N-1:0] act_nxt_s, pend_nxt_s;
  logic         pend_vld_r, pend_vld_nxt_s;

  // Moduli of 0 or 1 collapse to the minimum legal modulus.
  function automatic logic [N-1:0] eff_mod(input logic [N-1:0] v);
    if (v <= MIN_N) begin
      eff_mod = MIN_N;
    end else begin
      eff_mod = v;
    end
  endfunction

  assign eff_s = eff_mod(wr_val);

  // Next-state selection for the active and pending moduli.
  always_comb begin
    act_nxt_s      = act_r;
    pend_nxt_s     = pend_r;
    pend_vld_nxt_s = pend_vld_r;
    if (IMMEDIATE == UPD_NOW) begin
      if (wr) begin
        act_nxt_s = eff_s;
      end else begin
        act_nxt_s = act_r;
      end
    end else begin
      // An apply in the same cycle as a write takes the older pending value.
      if (apply && pend_vld_r) begin
        act_nxt_s = pend_r;
      end else begin
        act_nxt_s = act_r;
      end
      if (wr) begin
        pend_nxt_s     = eff_s;
        pend_vld_nxt_s = 1'b1;
      end else if (apply) begin
        pend_vld_nxt_s = 1'b0;
      end else begin
        pend_vld_nxt_s = pend_vld_r;
      end
    end
  end

  // Modulus state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_r      <= M_N;
      pend_r     <= M_N;
      pend_vld_r <= 1'b0;
    end else begin
      act_r      <= act_nxt_s;
      pend_r     <= pend_nxt_s;
      pend_vld_r <= pend_vld_nxt_s;
    end
  end

  assign active     = act_r;
  assign active_nxt = act_nxt_s;
endmodule

// File: rtl/mod_m_prog_counter.sv
// Run-time programmable modulus up/down counter with clear, load and cascade ticks.
module mod_m_prog_counter
  import mod_m_prog_counter_pkg::*;
#(
  parameter int N             = 4,
  parameter int M             = 10,
  parameter int UPD_IMMEDIATE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         mod_wr,
  input  logic [N-1:0] mod_in,
  output logic [N-1:0] q,
  output logic [N-1:0] mod_q,
  output logic         max_tick,
  output logic         min_tick
);
  localparam logic [N-1:0] ZERO_N = {N{1'b0}};
  localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] q_r, q_nxt_s;
  logic [N-1:0] mod_q_s, mod_nxt_s, mod_m1_s, mnxt_m1_s;
  logic         wrap_s, apply_s;

  mod_shadow_reg #(
    .N         (N),
    .M         (M),
    .IMMEDIATE (UPD_IMMEDIATE)
  ) u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (mod_wr),
    .wr_val     (mod_in),
    .apply      (apply_s),
    .active     (mod_q_s),
    .active_nxt (mod_nxt_s)
  );

  assign mod_m1_s  = mod_q_s - ONE_N;
  assign mnxt_m1_s = mod_nxt_s - ONE_N;
  assign wrap_s    = en & (up ? (q_r >= mod_m1_s) : (q_r == ZERO_N));
  assign apply_s   = clr | ld | wrap_s;

  // Count next state: clr > ld > step > hold.
  always_comb begin
    q_nxt_s = q_r;
    if (clr) begin
      q_nxt_s = ZERO_N;
    end else if (ld) begin
      q_nxt_s = (ld_val > mnxt_m1_s) ? mnxt_m1_s : ld_val;
    end else if (en) begin
      if (up) begin
        q_nxt_s = (q_r >= mod_m1_s) ? ZERO_N : (q_r + ONE_N);
      end else if (q_r == ZERO_N) begin
        q_nxt_s = mod_m1_s;
      end else if (q_r > mod_m1_s) begin
        q_nxt_s = mod_m1_s;
      end else begin
        q_nxt_s = q_r - ONE_N;
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= ZERO_N;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign q        = q_r;
  assign mod_q    = mod_q_s;
  assign max_tick = en & up & (q_r == mod_m1_s);
  assign min_tick = en & ~up & (q_r == ZERO_N);
endmodule

// File: tb/tb_mod_m_prog_counter.sv
// Directed bench for the programmable modulus counter in deferred and immediate update modes.
module tb_mod_m_prog_counter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, clr, ld, mod_wr;
  logic [3:0] ld_val, mod_in;
  logic [3:0] q, mod_q;
  logic       max_tick, min_tick;
  logic       i_en, i_up, i_clr, i_ld, i_mod_wr;
  logic [3:0] i_ld_val, i_mod_in;
  logic [3:0] i_q, i_mod_q;
  logic       i_max_tick, i_min_tick;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_m_prog_counter #(.N(4), .M(10), .UPD_IMMEDIATE(0)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .mod_wr(mod_wr), .mod_in(mod_in), .q(q), .mod_q(mod_q),
    .max_tick(max_tick), .min_tick(min_tick)
  );

  mod_m_prog_counter #(.N(4), .M(10), .UPD_IMMEDIATE(1)) dut_imm (
    .clk(clk), .reset_n(reset_n), .en(i_en), .up(i_up), .clr(i_clr), .ld(i_ld),
    .ld_val(i_ld_val), .mod_wr(i_mod_wr), .mod_in(i_mod_in), .q(i_q), .mod_q(i_mod_q),
    .max_tick(i_max_tick), .min_tick(i_min_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0; up = 1'b0; clr = 1'b0; ld = 1'b0; mod_wr = 1'b0;
    ld_val = 4'd0; mod_in = 4'd0;
    i_en = 1'b0; i_up = 1'b0; i_clr = 1'b0; i_ld = 1'b0; i_mod_wr = 1'b0;
    i_ld_val = 4'd0; i_mod_in = 4'd0;
    #12;
    chk("rst_q", q, 0);
    chk("rst_mod", mod_q, 10);
    chk("rst_max", max_tick, 0);
    chk("rst_min", min_tick, 0);
    step();
    reset_n = 1'b1;

    // Default modulus up count.
    en = 1'b1; up = 1'b1;
    #1;
    for (int i = 0; i < 25; i++) begin
      chk("up_q", q, i % 10);
      chk("up_max", max_tick, (i % 10 == 9) ? 1 : 0);
      step();
    end
    chk("up_end_q", q, 5);

    // Down count from zero.
    clr = 1'b1; en = 1'b0;
    step();
    clr = 1'b0;
    chk("clr_q", q, 0);
    en = 1'b1; up = 1'b0;
    #1;
    chk("dn_min0", min_tick, 1);
    chk("dn_max0", max_tick, 0);
    step();
    for (int k = 9; k >= 1; k--) begin
      chk("dn_q", q, k);
      chk("dn_min", min_tick, 0);
      step();
    end
    chk("dn_q0", q, 0);
    chk("dn_min_end", min_tick, 1);
    en = 1'b0;
    #1;
    chk("dn_min_en0", min_tick, 0);

    // Deferred modulus update.
    en = 1'b1; up = 1'b1;
    step(); step(); step();
    chk("sh_q3", q, 3);
    mod_wr = 1'b1; mod_in = 4'd5;
    step();
    mod_wr = 1'b0;
    chk("sh_q4", q, 4);
    chk("sh_mod_hold", mod_q, 10);
    for (int i = 0; i < 5; i++) step();
    chk("sh_q9", q, 9);
    chk("sh_mod_q9", mod_q, 10);
    chk("sh_max9", max_tick, 1);
    step();
    chk("sh_wrap_q", q, 0);
    chk("sh_mod5", mod_q, 5);
    for (int i = 0; i < 10; i++) begin
      chk("m5_q", q, i % 5);
      chk("m5_max", max_tick, (i % 5 == 4) ? 1 : 0);
      step();
    end
    mod_wr = 1'b1; mod_in = 4'd1;
    step();
    mod_wr = 1'b0;
    chk("m1_pend_mod", mod_q, 5);
    step(); step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("m1_q", q, 0);
      chk("m1_mod", mod_q, 1);
      chk("m1_max", max_tick, 1);
      step();
    end

    // Write during a wrap only becomes pending.
    mod_wr = 1'b1; mod_in = 4'd10;
    step();
    mod_wr = 1'b0;
    chk("simul_mod_old", mod_q, 1);
    chk("simul_q", q, 0);
    step();
    chk("simul_mod_new", mod_q, 10);
    chk("simul_q2", q, 0);
    step(); step(); step();
    chk("pri_q3", q, 3);

    // Priority and load saturation.
    clr = 1'b1; ld = 1'b1; ld_val = 4'd7;
    step();
    chk("pri_clr", q, 0);
    clr = 1'b0; ld_val = 4'd15;
    step();
    chk("ld_sat", q, 9);
    ld = 1'b0; en = 1'b0;
    mod_wr = 1'b1; mod_in = 4'd4;
    step();
    mod_wr = 1'b0;
    chk("ld_pend_mod", mod_q, 10);
    ld = 1'b1; ld_val = 4'd15;
    step();
    ld = 1'b0;
    chk("ld_new_mod", mod_q, 4);
    chk("ld_new_sat", q, 3);

    // Async reset discards a pending modulus.
    mod_wr = 1'b1; mod_in = 4'd10;
    step();
    mod_wr = 1'b0; ld = 1'b1; ld_val = 4'd6;
    step();
    ld = 1'b0;
    chk("pre_rst_q", q, 6);
    chk("pre_rst_mod", mod_q, 10);
    mod_wr = 1'b1; mod_in = 4'd3;
    step();
    mod_wr = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_mod", mod_q, 10);
    step();
    reset_n = 1'b1;
    ld = 1'b1; ld_val = 4'd15;
    step();
    ld = 1'b0;
    chk("arst_no_pend_q", q, 9);
    chk("arst_no_pend_mod", mod_q, 10);

    // Immediate modulus update.
    i_ld = 1'b1; i_ld_val = 4'd8;
    step();
    i_ld = 1'b0; i_mod_wr = 1'b1; i_mod_in = 4'd4;
    step();
    i_mod_wr = 1'b0;
    chk("imm_mod", i_mod_q, 4);
    chk("imm_q", i_q, 8);
    i_en = 1'b1; i_up = 1'b1;
    #1;
    chk("imm_max", i_max_tick, 0);
    step();
    chk("imm_up_q", i_q, 0);
    i_en = 1'b0; i_mod_wr = 1'b1; i_mod_in = 4'd10;
    step();
    i_mod_wr = 1'b0; i_ld = 1'b1; i_ld_val = 4'd8;
    step();
    i_ld = 1'b0; i_mod_wr = 1'b1; i_mod_in = 4'd4;
    step();
    i_mod_wr = 1'b0;
    chk("imm_q8", i_q, 8);
    i_en = 1'b1; i_up = 1'b0;
    #1;
    chk("imm_min", i_min_tick, 0);
    step();
    chk("imm_dn_q", i_q, 3);
    i_en = 1'b0; i_mod_wr = 1'b1; i_mod_in = 4'd0;
    step();
    i_mod_wr = 1'b0;
    chk("imm_mod0", i_mod_q, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
